// File: rtl/hilo_ctrl_pkg.sv
// rtl/hilo_ctrl_pkg.sv - shared widths, funct codes, FSM states and mult/div decode for HI/LO control
package hilo_ctrl_pkg;

  localparam int DATA_BUS        = 32;
  localparam int DOUBLE_DATA_BUS = 64;
  localparam int FUNCT_BUS       = 6;

  localparam logic [FUNCT_BUS-1:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Shared with the hazard unit so both agree on which functs occupy the mult/div unit.
  function automatic logic is_md_funct(input logic [FUNCT_BUS-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - architectural HI/LO register pair with independent write enables
module hilo_reg
  import hilo_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hi_we,
  input  logic [DATA_BUS-1:0] hi_d,
  input  logic                lo_we,
  input  logic [DATA_BUS-1:0] lo_d,
  output logic [DATA_BUS-1:0] hi,
  output logic [DATA_BUS-1:0] lo
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - tracks mult/div from issue to EX exit, stalls while busy, commits HI/LO
module hilo_ctrl
  import hilo_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FUNCT_BUS-1:0]       funct,
  input  logic [DATA_BUS-1:0]        operand_1,
  input  logic                       stall_all,
  input  logic                       flush,
  input  logic                       md_done,
  input  logic [DOUBLE_DATA_BUS-1:0] md_result,
  output logic                       stall_request,
  output logic [DATA_BUS-1:0]        hi,
  output logic [DATA_BUS-1:0]        lo,
  output logic [DATA_BUS-1:0]        mf_result
);

  md_state_t                  state, state_next;
  logic [DOUBLE_DATA_BUS-1:0] res_buf;
  logic                       capture;
  logic                       commit;
  logic                       mthi_we, mtlo_we;
  logic                       hi_we, lo_we;
  logic [DATA_BUS-1:0]        hi_d, lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      res_buf <= '0;
    end else begin
      state <= state_next;
      if (capture) res_buf <= md_result;
    end
  end

  always_comb begin
    state_next    = state;
    capture       = 1'b0;
    commit        = 1'b0;
    mthi_we       = 1'b0;
    mtlo_we       = 1'b0;
    stall_request = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!flush) begin
            // The issue cycle itself stalls so EX holds the instruction until DONE.
            if (is_md_funct(funct)) begin
              stall_request = 1'b1;
              state_next    = BUSY;
            end
            mthi_we = (funct == FUNCT_MTHI) && !stall_all;
            mtlo_we = (funct == FUNCT_MTLO) && !stall_all;
          end
        end
        BUSY: begin
          stall_request = 1'b1;
          if (flush) begin
            state_next = IDLE;
          end else if (md_done) begin
            capture    = 1'b1;
            state_next = DONE;
          end
        end
        DONE: begin
          if (flush) begin
            state_next = IDLE;
          end else if (!stall_all) begin
            commit     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign hi_we = commit || mthi_we;
  assign lo_we = commit || mtlo_we;
  assign hi_d  = commit ? res_buf[63:32] : operand_1;
  assign lo_d  = commit ? res_buf[31:0]  : operand_1;

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .hi_we (hi_we),
    .hi_d  (hi_d),
    .lo_we (lo_we),
    .lo_d  (lo_d),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    mf_result = '0;
    if (funct == FUNCT_MFHI)      mf_result = hi;
    else if (funct == FUNCT_MFLO) mf_result = lo;
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - directed self-checking bench for hilo_ctrl
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic        stall_all;
  logic        flush;
  logic        md_done;
  logic [63:0] md_result;
  logic        stall_request;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_result;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] NOP = 6'b000000;

  hilo_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .funct         (funct),
    .operand_1     (operand_1),
    .stall_all     (stall_all),
    .flush         (flush),
    .md_done       (md_done),
    .md_result     (md_result),
    .stall_request (stall_request),
    .hi            (hi),
    .lo            (lo),
    .mf_result     (mf_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; funct = FUNCT_MULT; operand_1 = '0; stall_all = 1'b0;
    flush = 1'b0; md_done = 1'b0; md_result = '0;
    tick(); tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall_request, 0);
    rst = 1'b0; funct = NOP; #1;
    chk("post_rst_stall", stall_request, 0);
    chk("post_rst_mf", mf_result, 0);

    // MULT at minimum latency
    funct = FUNCT_MULT; #1;
    chk("mult_issue_stall", stall_request, 1);
    tick();
    md_done = 1'b1; md_result = 64'hFFFFFFFF_FFFFFFFA; #1;
    chk("mult_busy_stall", stall_request, 1);
    chk("mult_busy_hi", hi, 0);
    tick();
    md_done = 1'b0; #1;
    chk("mult_done_stall", stall_request, 0);
    chk("mult_done_hi", hi, 0);
    tick();
    funct = FUNCT_MFHI; #1;
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("mult_mfhi", mf_result, 32'hFFFFFFFF);
    chk("mult_idle_stall", stall_request, 0);
    funct = FUNCT_MFLO; #1;
    chk("mult_mflo", mf_result, 32'hFFFFFFFA);

    // DIV with long latency and a 3-cycle hold in DONE
    funct = FUNCT_DIV; tick();
    for (int i = 0; i < 39; i++) tick();
    chk("div_wait_stall", stall_request, 1);
    chk("div_wait_hi", hi, 32'hFFFFFFFF);
    md_done = 1'b1; md_result = {32'd1, 32'd3}; tick();
    md_done = 1'b0; stall_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("div_hold_hi", hi, 32'hFFFFFFFF);
      chk("div_hold_lo", lo, 32'hFFFFFFFA);
      chk("div_hold_stall", stall_request, 0);
    end
    stall_all = 1'b0; tick();
    funct = NOP; #1;
    chk("div_hi", hi, 1);
    chk("div_lo", lo, 3);

    // md_done held high: only the first captured value commits
    funct = FUNCT_MULTU; tick();
    md_done = 1'b1; md_result = 64'h00000002_00000005; tick();
    md_result = 64'h77777777_88888888; stall_all = 1'b1; tick();
    stall_all = 1'b0; md_done = 1'b0; tick();
    funct = NOP; #1;
    chk("held_done_hi", hi, 2);
    chk("held_done_lo", lo, 5);

    // MTHI / MFHI, MTLO under stall, flushed MTHI
    funct = FUNCT_MTHI; operand_1 = 32'hDEADBEEF; tick();
    funct = FUNCT_MFHI; #1;
    chk("mthi_mfhi", mf_result, 32'hDEADBEEF);
    funct = FUNCT_MTLO; operand_1 = 32'h12345678; stall_all = 1'b1; tick();
    chk("mtlo_stalled_lo", lo, 5);
    stall_all = 1'b0; tick();
    chk("mtlo_retry_lo", lo, 32'h12345678);
    funct = FUNCT_MTHI; operand_1 = 32'h0; flush = 1'b1; stall_all = 1'b1; tick();
    chk("mthi_flush_hi", hi, 32'hDEADBEEF);
    stall_all = 1'b0; funct = FUNCT_MULT; #1;
    chk("issue_flush_stall", stall_request, 0);
    flush = 1'b0;

    // flush in BUSY discards the late result
    tick();
    flush = 1'b1; tick();
    flush = 1'b0; funct = NOP; md_done = 1'b1; md_result = 64'hAAAAAAAA_BBBBBBBB; tick();
    md_done = 1'b0; tick(); tick();
    chk("flush_busy_hi", hi, 32'hDEADBEEF);
    chk("flush_busy_lo", lo, 32'h12345678);
    chk("flush_busy_stall", stall_request, 0);

    // reset while DONE holds a pending result
    funct = FUNCT_MULT; tick();
    md_done = 1'b1; md_result = 64'h12345678_9ABCDEF0; tick();
    md_done = 1'b0; stall_all = 1'b1; rst = 1'b1; tick();
    chk("rst_done_hi", hi, 0);
    chk("rst_done_lo", lo, 0);
    rst = 1'b0; stall_all = 1'b0; funct = NOP; tick(); tick();
    chk("rst_done_after_hi", hi, 0);
    chk("rst_done_after_lo", lo, 0);
    chk("rst_done_after_stall", stall_request, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Owner of the architectural HI/LO register pair in the EX stage, directly downstream of the multiply/divide unit. Tracks each MULT/MULTU/DIV/DIVU from issue to completion, requests a pipeline stall while the unit is working, and buffers the 64-bit result. It commits that result to HI/LO only when the instruction actually leaves EX. It also executes MTHI/MTLO and supplies the read value for MFHI/MFLO.

## Interface
- No parameters. Widths come from `DATA_BUS` (32), `DOUBLE_DATA_BUS` (64) and `FUNCT_BUS` (6); funct codes come from the shared funct header.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- funct  in  FUNCT_BUS  funct of the instruction currently in EX.
- operand_1  in  DATA_BUS  rs value; the write data for MTHI/MTLO.
- stall_all  in  1  global stall; EX holds its instruction while this is high.
- flush  in  1  kills the instruction in EX (exception or branch squash).
- md_done  in  1  done flag from the multiply/divide unit.
- md_result  in  DOUBLE_DATA_BUS  result from the unit: {hi, lo} for multiply, {remainder, quotient} for divide.
- stall_request  out  1  asks the hazard unit to stall the pipeline.
- hi  out  DATA_BUS  architectural HI; also fed back to the unit.
- lo  out  DATA_BUS  architectural LO; also fed back to the unit.
- mf_result  out  DATA_BUS  result of MFHI/MFLO; 0 for any other funct.

## Operation
- State machine states: IDLE, BUSY, DONE. A 64-bit buffer res_buf holds the pending result.
- IDLE:
  - MULT/MULTU/DIV/DIVU with flush=0 -> BUSY. md_done is ignored in IDLE.
  - MTHI with stall_all=0 and flush=0 -> hi <= operand_1. MTLO does the same for lo. No state change.
- BUSY:
  - stall_request=1.
  - md_done=1 -> res_buf <= md_result, then -> DONE.
- DONE:
  - stall_request=0.
  - stall_all=0 -> hi <= res_buf[63:32], lo <= res_buf[31:0], then -> IDLE.
  - stall_all=1 -> stay in DONE; res_buf is held.
- Priority: rst > flush > everything else.
  - flush in any state -> IDLE. No HI/LO write; any pending result is discarded.
- mf_result is combinational:
  - MFHI -> hi, MFLO -> lo, otherwise 0.
  - Commits happen only at EX exit, so the next instruction always reads updated HI/LO and no bypass is needed.
- stall_request is a combinational decode: it is 1 in BUSY, and also in IDLE whenever a mult/div funct is present and flush=0. This stalls the issue cycle itself.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, res_buf=0, stall_request=0, mf_result=0.
- Reset mid-operation (BUSY or DONE): returns to IDLE next edge and drops any pending result.
- Minimum MULT latency:
  - issue cycle T (IDLE, stall_request=1);
  - md_done at T+1 captured (BUSY -> DONE);
  - commit at T+2 if stall_all=0.
  - HI/LO are visible from T+3.
- DIV: commit occurs 1 cycle after the BUSY cycle in which md_done is first seen with stall_all=0. No upper bound on the wait.
- md_done held high across several cycles in BUSY: only the first edge captures; DONE ignores md_done.
- MTHI/MTLO under stall_all=1: no write; the instruction is retried when the stall releases.
- flush and stall_all together: flush wins.

## Structure
- State encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) go in a shared header alongside bus.v and funct.v. The mult/div funct-class decode also goes there as a macro so the hazard unit can reuse it.
- One sub-module is natural: hilo_reg, a pair of 32-bit registers with independent write enables, synchronous active-high reset to 0.

## Test plan
- Reset: assert rst with funct=MULT in flight -> hi=lo=0, stall_request=0 on the next cycle and after release.
- MULT path: funct=MULT; md_done=1 one cycle later with md_result=64'hFFFFFFFF_FFFFFFFA; stall_all=0 -> stall_request 1 for 2 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- DIV path: md_done arrives after 40 cycles with md_result={32'd1, 32'd3}; stall_all held high for 3 cycles in DONE -> HI/LO unchanged during the hold, then hi=1, lo=3 one cycle after release.
- MTHI/MFHI:
  - MTHI with operand_1=32'hDEADBEEF, then MFHI -> mf_result=32'hDEADBEEF.
  - MTLO under stall_all=1 -> lo unchanged.
- Flush: flush=1 in BUSY, then md_done=1 -> state IDLE, hi/lo keep their prior values, stall_request=0.
- Reset mid-DONE: rst=1 with res_buf=64'h1234_5678_9ABC_DEF0 -> hi=lo=0, no commit afterwards.
